seg_counter_top: RTL and testbench

SEG_COUNTER_TOP -- requirements
Module: seg_counter_top

---
 rtl/seg_counter_pkg.sv | 45 ++++
 rtl/bcd_digit.sv | 48 ++++
 rtl/seg_counter_top.sv | 168 ++++++++++++++++
 tb/tb_seg_counter_top.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_counter_pkg.sv
// Shared definitions for the seg_counter block.
//   bcd_t          : one BCD digit (4 bits, values 0..9)
//   Seg*           : active-low seven-segment patterns, bit order a..g (MSB = a)
//   seg_encode()   : BCD digit -> segment pattern (non-BCD codes show blank)
//   idx_width()    : width of a digit index for a given digit count
package seg_counter_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SegDigit0 = 7'b0000001;
  localparam logic [6:0] SegDigit1 = 7'b1001111;
  localparam logic [6:0] SegDigit2 = 7'b0010010;
  localparam logic [6:0] SegDigit3 = 7'b0000110;
  localparam logic [6:0] SegDigit4 = 7'b1001100;
  localparam logic [6:0] SegDigit5 = 7'b0100100;
  localparam logic [6:0] SegDigit6 = 7'b0100000;
  localparam logic [6:0] SegDigit7 = 7'b0001111;
  localparam logic [6:0] SegDigit8 = 7'b0000000;
  localparam logic [6:0] SegDigit9 = 7'b0000100;
  localparam logic [6:0] SegBlank  = 7'b1111111;

  function automatic logic [6:0] seg_encode(bcd_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SegDigit0;
      4'd1:    s = SegDigit1;
      4'd2:    s = SegDigit2;
      4'd3:    s = SegDigit3;
      4'd4:    s = SegDigit4;
      4'd5:    s = SegDigit5;
      4'd6:    s = SegDigit6;
      4'd7:    s = SegDigit7;
      4'd8:    s = SegDigit8;
      4'd9:    s = SegDigit9;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // A single digit still needs a 1-bit index register.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter.
//   clk, i_reset : clock, synchronous active-high reset
//   inc, dec     : step this digit up / down this cycle (never both)
//   clear        : force the digit to 0 at the next edge
//   value        : current digit 0..9
//   carry        : digit is 9, so an increment here ripples into the next decade
//   borrow       : digit is 0, so a decrement here ripples into the next decade
// carry/borrow are level flags from the register only; the top gates them with the
// step request so the ripple chain never forms a combinational loop through digits.
module bcd_digit
  import seg_counter_pkg::*;
(
  input  logic clk,
  input  logic i_reset,
  input  logic inc,
  input  logic dec,
  input  logic clear,
  output bcd_t value,
  output logic carry,
  output logic borrow
);

  bcd_t value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = 4'd0;
    end else if (inc) begin
      value_d = (value_q == 4'd9) ? 4'd0 : value_q + 4'd1;
    end else if (dec) begin
      value_d = (value_q == 4'd0) ? 4'd9 : value_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value  = value_q;
  assign carry  = (value_q == 4'd9);
  assign borrow = (value_q == 4'd0);

endmodule

// File: rtl/seg_counter_top.sv
// Multi-digit BCD up/down counter driving a multiplexed seven-segment display.
// Parameters: DIGITS (1..4), TICK_DIV (cycles per count tick), SCAN_DIV (cycles per digit slot).
// Ports:
//   clk      : clock, all logic on rising edge
//   i_reset  : synchronous active-high reset (highest priority)
//   i_en     : count enable, sampled on tick cycles
//   i_dir    : 1 = count up, 0 = count down
//   i_clear  : synchronous clear of the count value only
//   o_led    : toggles on every count wrap
//   seg[0:6] : segments a..g, active-low, registered
//   an[0:D-1]: digit anodes, active-low, an[0] = least-significant digit, registered
//   dp       : decimal point, active-low, always off
// Build option: define SEG_COUNTER_BLANK_EN to blank leading zero digits (digit 0 never blanks).
module seg_counter_top
  import seg_counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic              i_dir,
  input  logic              i_clear,
  output logic              o_led,
  output logic [0:6]        seg,
  output logic [0:DIGITS-1] an,
  output logic              dp
);

  localparam int TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IdxW  = int'(idx_width(DIGITS));

  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
  localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]  IdxMax  = IdxW'(DIGITS - 1);

  // Count tick prescaler
  logic [TickW-1:0] tick_q, tick_d;
  logic             tick;

  assign tick   = (tick_q == TickMax);
  assign tick_d = tick ? '0 : tick_q + TickW'(1);

  // Digit chain
  logic              up_step, dn_step;
  logic [DIGITS-1:0] inc_v, dec_v, carry_v, borrow_v;
  bcd_t              digit_val [DIGITS];
  logic              wrap;

  assign up_step = tick & i_en & i_dir;
  assign dn_step = tick & i_en & ~i_dir;

  // A digit steps when every lower digit is at its carry/borrow limit; the accumulator
  // left over after the top digit is the whole-counter wrap.
  always_comb begin
    logic up_acc, dn_acc;
    up_acc = up_step;
    dn_acc = dn_step;
    inc_v  = '0;
    dec_v  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      inc_v[i] = up_acc;
      dec_v[i] = dn_acc;
      up_acc   = up_acc & carry_v[i];
      dn_acc   = dn_acc & borrow_v[i];
    end
    // A clear overrides the coincident tick, so it cannot produce a wrap either.
    wrap = (up_acc | dn_acc) & ~i_clear;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .i_reset(i_reset),
      .inc    (inc_v[g]),
      .dec    (dec_v[g]),
      .clear  (i_clear),
      .value  (digit_val[g]),
      .carry  (carry_v[g]),
      .borrow (borrow_v[g])
    );
  end

  // Wrap indicator
  logic led_q, led_d;
  assign led_d = led_q ^ wrap;

  // Display scan
  logic [ScanW-1:0] scan_q, scan_d;
  logic             scan_tick;
  logic [IdxW-1:0]  idx_q, idx_d;

  assign scan_tick = (scan_q == ScanMax);
  assign scan_d    = scan_tick ? '0 : scan_q + ScanW'(1);

  always_comb begin
    idx_d = idx_q;
    if (scan_tick) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
    end
  end

  // Leading-zero blanking mask
  logic [DIGITS-1:0] blank;

`ifdef SEG_COUNTER_BLANK_EN
  always_comb begin
    logic lead;
    lead  = 1'b1;
    blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead     = lead & (digit_val[i] == 4'd0);
      blank[i] = lead;
    end
  end
`else
  assign blank = '0;
`endif

  // Output registers are fed from the live count every cycle, so a count change is
  // visible on seg one cycle later without waiting for a slot boundary.
  logic [0:DIGITS-1] an_q, an_d;
  logic [0:6]        seg_q, seg_d;
  bcd_t              cur_val;
  logic              cur_blank;

  always_comb begin
    cur_val   = 4'd0;
    cur_blank = 1'b0;
    an_d      = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_val   = digit_val[i];
        cur_blank = blank[i];
        an_d[i]   = 1'b0;
      end
    end
    seg_d = cur_blank ? SegBlank : seg_encode(cur_val);
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      tick_q   <= '0;
      scan_q   <= '0;
      idx_q    <= '0;
      led_q    <= 1'b0;
      an_q     <= '1;
      an_q[0]  <= 1'b0;
      seg_q    <= SegDigit0;
    end else begin
      tick_q   <= tick_d;
      scan_q   <= scan_d;
      idx_q    <= idx_d;
      led_q    <= led_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign o_led = led_q;
  assign seg   = seg_q;
  assign an    = an_q;
  assign dp    = 1'b1;

endmodule

// File: tb/tb_seg_counter_top.sv
// Scoreboard bench for seg_counter_top with DIGITS=2, TICK_DIV=4, SCAN_DIV=2.
// A behavioural model predicts an/seg/o_led for each edge; predictions are queued when the
// inputs are driven and popped once the DUT outputs have settled after the edge.
module tb_seg_counter_top;

  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;

  logic       clk = 1'b0;
  logic       i_reset, i_en, i_dir, i_clear;
  logic       o_led, dp;
  logic [0:6] seg;
  logic [0:1] an;

  always #5 clk = ~clk;

  seg_counter_top #(
    .DIGITS  (DIGITS),
    .TICK_DIV(TICK_DIV),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk    (clk),
    .i_reset(i_reset),
    .i_en   (i_en),
    .i_dir  (i_dir),
    .i_clear(i_clear),
    .o_led  (o_led),
    .seg    (seg),
    .an     (an),
    .dp     (dp)
  );

  typedef struct packed {
    logic [1:0] an;
    logic [6:0] seg;
    logic       led;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int m_cnt = 0;
  int m_pre = 0;
  int m_scan = 0;
  int m_idx = 0;
  int m_led = 0;

  localparam logic [6:0] Blank = 7'b1111111;
`ifdef SEG_COUNTER_BLANK_EN
  localparam logic [6:0] HiZero = 7'b1111111;
`else
  localparam logic [6:0] HiZero = 7'b0000001;
`endif

  function automatic logic [6:0] enc(int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return Blank;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(int cnt, int idx);
    if (idx == 0) return enc(cnt % 10);
`ifdef SEG_COUNTER_BLANK_EN
    if (cnt / 10 == 0) return Blank;
`endif
    return enc(cnt / 10);
  endfunction

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Predict one edge, push the prediction, advance the clock, then score.
  task automatic step();
    exp_t e;
    exp_t got;
    if (i_reset) begin
      m_cnt  = 0;
      m_pre  = 0;
      m_scan = 0;
      m_idx  = 0;
      m_led  = 0;
      e.an   = 2'b01;
      e.seg  = 7'b0000001;
    end else begin
      e.an  = (m_idx == 0) ? 2'b01 : 2'b10;
      e.seg = model_seg(m_cnt, m_idx);
      if (i_clear) begin
        m_cnt = 0;
      end else if (m_pre == TICK_DIV - 1 && i_en) begin
        if (i_dir) begin
          if (m_cnt == 99) begin
            m_cnt = 0;
            m_led = m_led ^ 1;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end else begin
          if (m_cnt == 0) begin
            m_cnt = 99;
            m_led = m_led ^ 1;
          end else begin
            m_cnt = m_cnt - 1;
          end
        end
      end
      m_pre = (m_pre + 1) % TICK_DIV;
      if (m_scan == SCAN_DIV - 1) m_idx = (m_idx + 1) % DIGITS;
      m_scan = (m_scan + 1) % SCAN_DIV;
    end
    e.led = m_led[0];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_eq("sb_an", 32'(an), 32'(got.an));
    check_eq("sb_seg", 32'(seg), 32'(got.seg));
    check_eq("sb_led", 32'(o_led), 32'(got.led));
    check_eq("sb_dp", 32'(dp), 32'd1);
  endtask

  task automatic run_until_cnt(int target);
    for (int k = 0; k < 2000 && m_cnt != target; k++) step();
    if (m_cnt != target) check_eq("timeout_cnt", 32'(m_cnt), 32'(target));
  endtask

  task automatic run_until_tick_cycle();
    for (int k = 0; k < 2 * TICK_DIV && m_pre != TICK_DIV - 1; k++) step();
    if (m_pre != TICK_DIV - 1) check_eq("timeout_tick", 32'(m_pre), 32'(TICK_DIV - 1));
  endtask

  // Observe the display for n cycles against fixed per-slot patterns.
  task automatic show_digits(string tag, logic [6:0] s0, logic [6:0] s1, int n);
    for (int k = 0; k < n; k++) begin
      step();
      if (an == 2'b01) check_eq({tag, "_d0"}, 32'(seg), 32'(s0));
      else if (an == 2'b10) check_eq({tag, "_d1"}, 32'(seg), 32'(s1));
      else check_eq({tag, "_an"}, 32'(an), 32'(2'b01));
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_en    = 1'b0;
    i_dir   = 1'b1;
    i_clear = 1'b0;
    step();
    step();
    check_eq("rst_an", 32'(an), 32'(2'b01));
    check_eq("rst_seg", 32'(seg), 32'(7'b0000001));
    check_eq("rst_led", 32'(o_led), 32'd0);
    i_reset = 1'b0;

    // 40 cycles of up counting -> 10
    i_en = 1'b1;
    for (int k = 0; k < 40; k++) step();
    i_en = 1'b0;
    show_digits("cnt10", enc(0), enc(1), 4);
    check_eq("cnt10_led", 32'(o_led), 32'd0);

    // Up wrap 99 -> 00, then down wrap 00 -> 99
    i_en = 1'b1;
    run_until_cnt(99);
    run_until_cnt(0);
    check_eq("wrap_up_led", 32'(o_led), 32'd1);
    i_dir = 1'b0;
    run_until_cnt(99);
    check_eq("wrap_dn_led", 32'(o_led), 32'd0);
    i_en = 1'b0;
    show_digits("cnt99", enc(9), enc(9), 4);

    // Clear on a tick cycle at 57
    i_dir = 1'b1;
    i_en  = 1'b1;
    run_until_cnt(57);
    run_until_tick_cycle();
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    i_en    = 1'b0;
    show_digits("clr", enc(0), HiZero, 4);
    i_en = 1'b1;
    run_until_cnt(1);
    i_en = 1'b0;
    show_digits("clr_phase", enc(1), HiZero, 4);

    // Display scan at 42
    i_en = 1'b1;
    run_until_cnt(42);
    i_en = 1'b0;
    show_digits("cnt42", enc(2), enc(4), 8);

    // Reset on a tick cycle at 35
    i_en = 1'b1;
    run_until_cnt(35);
    run_until_tick_cycle();
    i_reset = 1'b1;
    step();
    check_eq("midrst_an", 32'(an), 32'(2'b01));
    check_eq("midrst_seg", 32'(seg), 32'(7'b0000001));
    check_eq("midrst_led", 32'(o_led), 32'd0);
    check_eq("midrst_dp", 32'(dp), 32'd1);
    i_reset = 1'b0;
    i_en    = 1'b0;
    show_digits("postrst", enc(0), HiZero, 4);

    // Leading-zero handling at 07 and 00
    i_en = 1'b1;
    run_until_cnt(7);
    i_en = 1'b0;
    show_digits("cnt07", enc(7), HiZero, 4);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    show_digits("cnt00", enc(0), HiZero, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
